// File: rtl/uart_access_arbiter.sv
// uart_access_arbiter
//   Shares the single simulation UART port between two MMIO requesters
//   (0 = core, 1 = debug). One valid/ready request is accepted at a time with
//   round-robin arbitration. It is then sequenced as a one-cycle wen/ren
//   strobe, a read-latency wait with rdata capture, and a response handshake
//   back to the owner. The UART irq level is registered once for the
//   interrupt controller.
//
// Parameters
//   ADDR_W  UART register address width
//   DATA_W  UART data width
//   RD_LAT  cycles from the ren strobe cycle to uart_rdata valid (1..15)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/ready             request handshake, requester N
//   reqN_write/addr/wdata        request payload (write=1, read=0)
//   respN_valid/ready/rdata      response handshake; rdata is 0 for writes
//   uart_wen/waddr/wdata         UART write strobe and payload
//   uart_ren/raddr/rdata         UART read strobe, address, returned data
//   uart_irq, irq_out            UART interrupt level and its registered copy
module uart_access_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic [DATA_W-1:0] resp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp1_rdata,
   output logic              uart_wen,
   output logic [ADDR_W-1:0] uart_waddr,
   output logic [DATA_W-1:0] uart_wdata,
   output logic              uart_ren,
   output logic [ADDR_W-1:0] uart_raddr,
   input  logic [DATA_W-1:0] uart_rdata,
   input  logic              uart_irq,
   output logic              irq_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] LAT = 4'(RD_LAT);

   state_t            state_q, state_d;
   logic              last_grant_q;
   logic              owner_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        cnt_q;

   logic gnt0, gnt1, accept, resp_take;

   // Round-robin: a lone requester always wins; on a tie the requester that
   // was not served last wins.
   assign gnt0      = req0_valid & (~req1_valid | last_grant_q);
   assign gnt1      = req1_valid & (~req0_valid | ~last_grant_q);
   assign accept    = (state_q == IDLE) & (gnt0 | gnt1);
   assign resp_take = owner_q ? resp1_ready : resp0_ready;

   // Address/data always come from the latched request; only the strobes
   // qualify them.
   assign uart_waddr = addr_q;
   assign uart_raddr = addr_q;
   assign uart_wdata = wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      // rst_n gating keeps the combinational readies low while reset is held.
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      resp0_rdata = '0;
      resp1_rdata = '0;
      uart_wen    = 1'b0;
      uart_ren    = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = gnt0 & rst_n;
            req1_ready = gnt1 & rst_n;
            if (accept) state_d = ISSUE;
         end
         ISSUE: begin
            uart_wen = wr_q;
            uart_ren = ~wr_q;
            state_d  = wr_q ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            resp0_valid = ~owner_q;
            resp1_valid = owner_q;
            if (owner_q) resp1_rdata = rdata_q;
            else         resp0_rdata = rdata_q;
            if (resp_take) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         if (accept) begin
            owner_q <= gnt1;
            wr_q    <= gnt1 ? req1_write : req0_write;
            addr_q  <= gnt1 ? req1_addr  : req0_addr;
            wdata_q <= gnt1 ? req1_wdata : req0_wdata;
            rdata_q <= '0;   // writes respond with zero data
         end
         if (state_q == ISSUE) cnt_q <= LAT;
         if (state_q == WAIT) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) rdata_q <= uart_rdata;
         end
         if (state_q == RESP && resp_take) last_grant_q <= owner_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_out <= 1'b0;
      else        irq_out <= uart_irq;
   end

endmodule
